// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter that lends one status LED to NUM_REQ requesters and plays each blink code.
// Optional idle heartbeat: define HEARTBEAT_IDLE_EN.
module led_blink_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned TICK_DIV  = 10000000,
  parameter int unsigned ON_TICKS  = 2,
  parameter int unsigned OFF_TICKS = 3,
  parameter int unsigned GAP_TICKS = 10,
  localparam int unsigned GID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     a_reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] blink_cnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     busy,
  output logic [GID_W-1:0]         grant_id,
  output logic                     led_out
);

  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PH_MAX = (ON_TICKS > OFF_TICKS) ?
                                   ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS) :
                                   ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {StIdle, StOn, StOff, StGap, StAck} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [GID_W-1:0]   gid_q, gid_d;
  logic [GID_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               led_q, led_d;

  logic               tick;
  logic [GID_W-1:0]   winner;
  logic [CNT_W-1:0]   win_cnt;

  assign tick = (div_q == DIV_W'(TICK_DIV - 1));

  // Round-robin search starting just after the last acknowledged requester.
  always_comb begin
    logic        found;
    int unsigned idx;
    winner  = '0;
    win_cnt = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(last_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[GID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[GID_W-1:0];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (GID_W'(i) == winner) win_cnt = blink_cnt[i*CNT_W +: CNT_W];
    end
  end

`ifdef HEARTBEAT_IDLE_EN
  localparam int unsigned HB_TICKS = ON_TICKS + OFF_TICKS;
  localparam int unsigned HB_W     = $clog2(HB_TICKS);
  logic [HB_W-1:0] hb_q, hb_d;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    phase_d = phase_q;
    rem_d   = rem_q;
    gid_d   = gid_q;
    last_d  = last_q;
    ack_d   = '0;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          gid_d   = winner;
          rem_d   = win_cnt;
          div_d   = '0;
          phase_d = '0;
          state_d = (win_cnt == '0) ? StAck : StOn;
        end
      end
      StOn: begin
        if (tick) begin
          if (phase_q == PH_W'(ON_TICKS - 1)) begin
            phase_d = '0;
            rem_d   = rem_q - CNT_W'(1);
            state_d = StOff;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      StOff: begin
        if (tick) begin
          if (phase_q == PH_W'(OFF_TICKS - 1)) begin
            phase_d = '0;
            state_d = (rem_q != '0) ? StOn : StGap;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      StGap: begin
        if (tick) begin
          if (phase_q == PH_W'(GAP_TICKS - 1)) begin
            phase_d = '0;
            state_d = StAck;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      StAck: begin
        last_d  = gid_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they align with the state register.
    if (state_d == StAck) ack_d[gid_d] = 1'b1;
    busy_d = (state_d != StIdle);

`ifdef HEARTBEAT_IDLE_EN
    led_d = (state_d == StOn);
    hb_d  = '0;
    if (state_q == StIdle && state_d == StIdle) begin
      led_d = led_q;
      hb_d  = hb_q;
      if (tick) begin
        if (hb_q == HB_W'(HB_TICKS - 1)) begin
          hb_d  = '0;
          led_d = ~led_q;
        end else begin
          hb_d = hb_q + HB_W'(1);
        end
      end
    end
`else
    led_d = (state_d == StOn);
`endif
  end

  always_ff @(posedge clk or posedge a_reset_n) begin
    if (a_reset_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      gid_q   <= '0;
      last_q  <= GID_W'(NUM_REQ - 1);
      ack_q   <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

`ifdef HEARTBEAT_IDLE_EN
  always_ff @(posedge clk or posedge a_reset_n) begin
    if (a_reset_n) hb_q <= '0;
    else           hb_q <= hb_d;
  end
`endif

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;
  assign led_out  = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Randomized self-checking bench for led_blink_arbiter; expected grants and LED waveforms
// come from round-robin arithmetic and the pulse/gap timing formulas.
module tb_led_blink_arbiter;

  localparam int unsigned NR   = 4;
  localparam int unsigned CW   = 4;
  localparam int unsigned TD   = 4;
  localparam int unsigned ONT  = 2;
  localparam int unsigned OFFT = 3;
  localparam int unsigned GAPT = 10;
  localparam int unsigned PER  = (ONT + OFFT) * TD;

  logic             clk = 1'b0;
  logic             a_reset_n;
  logic [NR-1:0]    req;
  logic [NR*CW-1:0] blink_cnt;
  logic [NR-1:0]    ack;
  logic             busy;
  logic [1:0]       grant_id;
  logic             led_out;

  always #5 clk = ~clk;

  led_blink_arbiter #(
    .NUM_REQ  (NR),
    .CNT_W    (CW),
    .TICK_DIV (TD),
    .ON_TICKS (ONT),
    .OFF_TICKS(OFFT),
    .GAP_TICKS(GAPT)
  ) dut (
    .clk      (clk),
    .a_reset_n(a_reset_n),
    .req      (req),
    .blink_cnt(blink_cnt),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .led_out  (led_out)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cnt_m[NR];
  int unsigned served[NR];
  int unsigned last_m;

  task automatic check_eq(input string tag, input longint unsigned got,
                          input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int unsigned rr_ref(input logic [NR-1:0] m, input int unsigned last);
    int unsigned idx;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = (last + k) % NR;
      if (m[idx[1:0]]) return idx;
    end
    return last;
  endfunction

  // LED is on during the first ON*TD cycles of each pulse period, dark afterwards.
  function automatic bit led_ref(input int unsigned k, input int unsigned n);
    if (k >= n * PER) return 1'b0;
    return (k % PER) < ONT * TD;
  endfunction

  task automatic drive_cnt();
    for (int i = 0; i < NR; i++) blink_cnt[i*CW +: CW] = CW'(cnt_m[i]);
  endtask

  task automatic serve(input bit extras, input int unsigned rst_at, output int unsigned w);
    int unsigned n, k, bad_led, bad_busy, exp_len, quiet;
    bit seen, got_ack, early;
    w       = rr_ref(req, last_m);
    n       = cnt_m[w];
    exp_len = (n == 0) ? 0 : (n * (ONT + OFFT) + GAPT) * TD;
    early   = extras && ($urandom_range(0, 3) == 0);
    seen    = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check_eq("busy_rise", seen, 1);
    if (!seen) begin
      req = '0;
      return;
    end
    check_eq("grant_id", grant_id, w);
    k = 0; bad_led = 0; bad_busy = 0; got_ack = 1'b0;
    while (!got_ack && k < 4000) begin
      if (led_out !== led_ref(k, n)) bad_led++;
      if (busy !== 1'b1) bad_busy++;
      if (ack != '0) begin
        got_ack = 1'b1;
      end else begin
        if (rst_at != 0 && k == rst_at) begin
          a_reset_n = 1'b1;
          #1;
          check_eq("reset_outputs_zero", {led_out, busy, ack, grant_id}, 0);
          req = '0;
          @(negedge clk);
          a_reset_n = 1'b0;
          quiet = 0;
          for (int i = 0; i < 60; i++) begin
            @(negedge clk);
`ifdef HEARTBEAT_IDLE_EN
            if (busy || ack != '0) quiet++;
`else
            if (busy || ack != '0 || led_out) quiet++;
`endif
          end
          check_eq("no_ack_after_reset", quiet, 0);
          last_m = NR - 1;
          return;
        end
        if (early && k == 1) req[w] = 1'b0;
        if (extras) blink_cnt = 16'($urandom);
        @(negedge clk);
        k++;
      end
    end
    check_eq("ack_seen", got_ack, 1);
    check_eq("ack_cycle", k, exp_len);
    check_eq("ack_vec", ack, 1 << w);
    check_eq("led_wave_errs", bad_led, 0);
    check_eq("busy_gap_errs", bad_busy, 0);
    if (!got_ack) req = '0;
    drive_cnt();
    last_m = w;
    served[w]++;
    @(negedge clk);
    check_eq("ack_one_cycle", ack, 0);
    check_eq("busy_fall", busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2ms, expected done");
    $fatal(1);
  end

  initial begin
    int unsigned w, errs, toggles, last_t, bad_gap;
    logic prev_led;
    a_reset_n = 1'b1;
    req       = '0;
    for (int i = 0; i < NR; i++) begin
      cnt_m[i]  = 0;
      served[i] = 0;
    end
    drive_cnt();
    last_m = NR - 1;
    repeat (3) @(negedge clk);
    check_eq("rst_led", led_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_grant_id", grant_id, 0);
    a_reset_n = 1'b0;

    // Quiet idle after reset.
    errs = 0; toggles = 0; last_t = 0; bad_gap = 0; prev_led = led_out;
    for (int unsigned c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (busy || ack != '0) errs++;
`ifdef HEARTBEAT_IDLE_EN
      if (led_out !== prev_led) begin
        if (toggles > 0 && c - last_t != PER) bad_gap++;
        toggles++;
        last_t = c;
      end
      prev_led = led_out;
`else
      if (led_out) errs++;
`endif
    end
    check_eq("idle_quiet_errs", errs, 0);
`ifdef HEARTBEAT_IDLE_EN
    check_eq("hb_toggle_spacing_errs", bad_gap, 0);
    check_eq("hb_toggles_ge9", toggles >= 9, 1);
`endif

    // Two simultaneous requesters from the reset search origin, held for a second round.
    cnt_m[0] = 1; cnt_m[2] = 2; drive_cnt();
    req = 4'b0101;
    serve(1'b0, 0, w);
    serve(1'b0, 0, w);
    serve(1'b0, 0, w);
    req = '0;

    // Zero-length code: single busy cycle carrying the ack.
    cnt_m[3] = 0; drive_cnt();
    req = 4'b1000;
    serve(1'b0, 0, w);
    req = '0;

    // Three pulses: 100 cycles from first rise to ack.
    cnt_m[1] = 3; drive_cnt();
    req = 4'b0010;
    serve(1'b0, 0, w);
    req = '0;

    // Reset during the second ON phase, then the search origin must be back at 0.
    cnt_m[0] = 0; drive_cnt();
    req = 4'b0001;
    serve(1'b0, 0, w);
    req = '0;
    cnt_m[1] = 2; cnt_m[2] = 2; drive_cnt();
    req = 4'b0110;
    serve(1'b0, PER + 3, w);
    cnt_m[0] = 1; cnt_m[2] = 1; drive_cnt();
    req = 4'b0101;
    serve(1'b0, 0, w);
    req = '0;

    // Maximum count: no wrap of the latched remaining count.
    cnt_m[2] = 15; drive_cnt();
    req = 4'b0100;
    serve(1'b1, 0, w);
    req = '0;

    // Random request mixes with scrambled counts mid-sequence and random drops.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NR; i++) begin
        cnt_m[i]  = $urandom_range(0, 4);
        served[i] = 0;
      end
      drive_cnt();
      req = 4'($urandom_range(1, 15));
      while (req != '0) begin
        serve(1'b1, 0, w);
        if (served[w] >= 2 || $urandom_range(0, 1) == 1) req[w] = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
